// File: rtl/i2c_share_arb.sv
`default_nettype none
// ============================================================================
// i2c_share_arb : round-robin arbiter sharing one I2C master among NREQ users
// Rev 1.0
// ============================================================================
module i2c_share_arb #(
   parameter int          NREQ     = 3,
   parameter logic [15:0] START_TO = 16'd4095
) (
   input  logic                 clk_i,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_i,
   input  logic [32*NREQ-1:0]   wr_data_i,
   input  logic [8*NREQ-1:0]    wr_cnt_i,
   input  logic [8*NREQ-1:0]    rd_cnt_i,
   input  logic [NREQ-1:0]      mode_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic [NREQ-1:0]      err_o,
   output logic [31:0]          rd_data_o,
   output logic [31:0]          iic_wr_data,
   output logic [7:0]           iic_wr_cnt,
   output logic [7:0]           iic_rd_cnt,
   output logic                 iic_mode,
   output logic                 iic_en,
   input  logic [31:0]          iic_rd_data,
   input  logic                 iic_busy
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [IW-1:0]   last_grant;
   logic [IW-1:0]   owner;
   logic [15:0]     to_cnt;

   logic [IW-1:0]   winner;
   logic            found;
   logic [IW:0]     idx;
   logic [31:0]     sel_wr_data;
   logic [7:0]      sel_wr_cnt;
   logic [7:0]      sel_rd_cnt;
   logic            sel_mode;

   // Search upward from the requester after last_grant, wrapping at NREQ.
   always_comb begin
      winner      = last_grant;
      found       = 1'b0;
      idx         = '0;
      sel_wr_data = '0;
      sel_wr_cnt  = '0;
      sel_rd_cnt  = '0;
      sel_mode    = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = {1'b0, last_grant} + (IW+1)'(i);
         if (idx >= (IW+1)'(NREQ)) begin
            idx = idx - (IW+1)'(NREQ);
         end
         if (!found && req_i[idx[IW-1:0]]) begin
            winner = idx[IW-1:0];
            found  = 1'b1;
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (winner == IW'(k)) begin
            sel_wr_data = wr_data_i[32*k +: 32];
            sel_wr_cnt  = wr_cnt_i[8*k +: 8];
            sel_rd_cnt  = rd_cnt_i[8*k +: 8];
            sel_mode    = mode_i[k];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state       <= IDLE;
         gnt_o       <= '0;
         done_o      <= '0;
         err_o       <= '0;
         iic_en      <= 1'b0;
         rd_data_o   <= '0;
         iic_wr_data <= '0;
         iic_wr_cnt  <= '0;
         iic_rd_cnt  <= '0;
         iic_mode    <= 1'b0;
         last_grant  <= IW'(NREQ-1);
         owner       <= '0;
         to_cnt      <= '0;
      end else begin
         done_o <= '0;
         err_o  <= '0;
         case (state)
            IDLE: begin
               if (!iic_busy && found) begin
                  owner       <= winner;
                  gnt_o       <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                  iic_wr_data <= sel_wr_data;
                  iic_wr_cnt  <= sel_wr_cnt;
                  iic_rd_cnt  <= sel_rd_cnt;
                  iic_mode    <= sel_mode;
                  iic_en      <= 1'b1;
                  to_cnt      <= '0;
                  state       <= START;
               end
            end
            START: begin
               if (iic_busy) begin
                  iic_en <= 1'b0;
                  state  <= RUN;
               end else if (to_cnt == START_TO - 16'd1) begin
                  // master never acknowledged the strobe: give up on this owner
                  err_o      <= gnt_o;
                  gnt_o      <= '0;
                  iic_en     <= 1'b0;
                  last_grant <= owner;
                  state      <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end
            RUN: begin
               if (!iic_busy) begin
                  done_o    <= gnt_o;
                  rd_data_o <= iic_rd_data;
                  state     <= DONE;
               end
            end
            DONE: begin
               gnt_o      <= '0;
               last_grant <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/i2c_share_arb.md
I2C_SHARE_ARB -- requirements
Module: i2c_share_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 3, number of requesters (2..4); START_TO, default 16'd4095, clk_i cycles allowed for iic_busy to rise after iic_en.
REQ-002 clk_i  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_i  input  NREQ  per-requester transaction request, level, held until done/err.
REQ-005 wr_data_i  input  32*NREQ  per-requester write bytes, slice k = bits [32k+31:32k].
REQ-006 wr_cnt_i  input  8*NREQ  per-requester write byte count.
REQ-007 rd_cnt_i  input  8*NREQ  per-requester read byte count.
REQ-008 mode_i  input  NREQ  per-requester iic_mode (0 write, 1 write-then-read).
REQ-009 gnt_o  output  NREQ  one-hot grant, high for the whole owned transaction.
REQ-010 done_o  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 err_o  output  NREQ  one-cycle timeout pulse to the granted requester.
REQ-012 rd_data_o  output  32  read data of the last completed transaction.
REQ-013 iic_wr_data  output  32, iic_wr_cnt  output  8, iic_rd_cnt  output  8, iic_mode  output  1  latched fields driven to the shared I2C master.
REQ-014 iic_en  output  1  start strobe to the I2C master.
REQ-015 iic_rd_data  input  32, iic_busy  input  1  from the I2C master.

Function
REQ-016 The FSM SHALL have states IDLE, START, RUN, DONE.
REQ-017 In IDLE with iic_busy=0 and any req_i bit set, the block SHALL select one requester by round-robin, searching upward from (last_grant+1) mod NREQ with wrap-around.
REQ-018 On the IDLE->START edge the block SHALL set gnt_o one-hot to the winner and latch its wr_data, wr_cnt, rd_cnt and mode into the iic_* outputs, which then stay constant until the next grant.
REQ-019 In IDLE with iic_busy=1, no grant SHALL be issued.
REQ-020 In START, iic_en SHALL be 1; when iic_busy=1 is sampled the FSM SHALL go to RUN, and iic_en SHALL be 0 from the next cycle.
REQ-021 A START timeout counter SHALL clear on entry to START; if it reaches START_TO without iic_busy=1, the block SHALL pulse err_o for the grantee for one cycle, drop iic_en and gnt_o, and return to IDLE.
REQ-022 In RUN, when iic_busy=0 is sampled the FSM SHALL go to DONE; RUN SHALL have no timeout.
REQ-023 In DONE, for exactly one cycle, done_o[grantee] SHALL be 1 and rd_data_o SHALL load iic_rd_data; last_grant SHALL update to the grantee; gnt_o SHALL clear on exit; next state IDLE.
REQ-024 last_grant SHALL also update on timeout exit.
REQ-025 Minimum request-to-iic_en latency SHALL be 1 cycle (req_i seen in IDLE, iic_en high next cycle).
REQ-026 req_i deasserting during START/RUN SHALL NOT abort the transaction; done_o/err_o SHALL still be issued.
REQ-027 req_i changes of non-granted requesters SHALL NOT affect the current transaction or latched fields.
REQ-028 A requester still requesting after its done SHALL lose to any other pending requester in the next arbitration.
REQ-029 At most one bit of gnt_o, done_o and err_o SHALL be high in any cycle; done_o and err_o SHALL never be high together.

Reset
REQ-030 While rst_n=0 on a clock edge: state IDLE, gnt_o=0, done_o=0, err_o=0, iic_en=0, rd_data_o=0, iic_wr_data=0, iic_wr_cnt=0, iic_rd_cnt=0, iic_mode=0, last_grant=NREQ-1 (so requester 0 wins first), timeout counter=0.
REQ-031 Reset asserted mid-transaction SHALL abort immediately with no done_o/err_o pulse; the external master is not reset by this block.

Verification
REQ-032 Single write: req_i=3'b001, wr_data_i[31:0]=32'h00_4C_98, wr_cnt 3, mode 0; model busy 1 cycle after iic_en for 50 cycles -> gnt_o=001, iic_en high until busy, iic_wr_data=32'h00004C98, done_o=001 one pulse, gnt_o=0.
REQ-033 Contention: req_i=3'b111 held -> grants in order 0,1,2,0 with one done_o pulse each; no gap other than the IDLE cycle.
REQ-034 Read: requester 2, mode 1, rd_cnt 1; master returns iic_rd_data=32'h000000A5 -> rd_data_o=32'h000000A5 in the cycle of done_o=100.
REQ-035 Timeout: START_TO=8, busy held 0 -> err_o pulse on cycle 8 of START, no done_o, iic_en low, next arbitration starts at requester+1.
REQ-036 Busy guard and reset: iic_busy=1 in IDLE with req_i=001 -> no grant until busy falls; rst_n=0 during RUN -> all outputs reset values next edge, no pulses.
